vec_add_sched: RTL and testbench

VEC_ADD_SCHED -- requirements
Module: vec_add_sched

---
 rtl/vec_add_sched_if.sv | 28 ++
 rtl/vec_add_sched.sv | 91 +++++++++
 tb/tb_vec_add_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_add_sched_if.sv
// Operand/result handshake bundle for vec_add_sched.
// The slave side is the adder block; the master side is the producer/consumer.
interface vec_add_sched_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned LANES = 5
);
    localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_a;
    logic [W-1:0]         in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   out_data;
    logic [LANES-1:0]     out_ovf;
    logic [IdxW-1:0]      lane_idx;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, lane_idx
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_ovf, lane_idx
    );
endinterface

// File: rtl/vec_add_sched.sv
// Time-shared W-bit adder packing LANES sums into one result vector.
// Optional macro VEC_ADD_SAT_EN clamps overflowing lane sums to all-ones.
module vec_add_sched #(
    parameter int unsigned W     = 16,
    parameter int unsigned LANES = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    vec_add_sched_if.slave  bus
);
    localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {StIdle, StFill, StHold} state_e;

    state_e               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [LANES*W-1:0]   r_data;
    logic [LANES-1:0]     r_ovf;
    logic [IdxW-1:0]      r_idx;

    logic                 w_hs;
    logic                 w_last;
    logic [W:0]           w_sum;
    logic                 w_carry;
    logic [W-1:0]         w_lane;

    assign w_hs    = bus.in_valid & r_in_ready;
    assign w_last  = (r_idx == IdxW'(LANES - 1));
    assign w_sum   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign w_carry = w_sum[W];

`ifdef VEC_ADD_SAT_EN
    assign w_lane = w_carry ? {W{1'b1}} : w_sum[W-1:0];
`else
    assign w_lane = w_sum[W-1:0];
`endif

    // r_idx is 0 in StIdle, so Idle and Fill share the lane-write path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_ovf       <= '0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                StIdle, StFill: begin
                    if (w_hs) begin
                        for (int unsigned k = 0; k < LANES; k++) begin
                            if (r_idx == IdxW'(k)) begin
                                r_data[(LANES-1-k)*W +: W] <= w_lane;
                                r_ovf[LANES-1-k]           <= w_carry;
                            end
                        end
                        if (w_last) begin
                            r_state     <= StHold;
                            r_idx       <= '0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= StFill;
                            r_idx   <= r_idx + IdxW'(1);
                        end
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_idx       <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_data;
    assign bus.out_ovf   = r_ovf;
    assign bus.lane_idx  = r_idx;
endmodule

// File: tb/tb_vec_add_sched.sv
// Directed bench for vec_add_sched: lane-level reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_vec_add_sched;
    localparam int unsigned W     = 16;
    localparam int unsigned LANES = 5;
    localparam int unsigned DW    = LANES * W;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    vec_add_sched_if #(.W(W), .LANES(LANES)) bus ();

    vec_add_sched #(.W(W), .LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lanes filled so far, and whether a full vector is waiting.
    logic [W-1:0] m_lane [LANES];
    logic         m_ovf  [LANES];
    int           m_cnt;
    logic         m_hold;
    wire  [W:0]   m_sum = {1'b0, bus.in_a} + {1'b0, bus.in_b};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                m_lane[k] <= '0;
                m_ovf[k]  <= 1'b0;
            end
            m_cnt  <= 0;
            m_hold <= 1'b0;
        end else if (m_hold) begin
            if (bus.out_ready) m_hold <= 1'b0;
        end else if (bus.in_valid) begin
`ifdef VEC_ADD_SAT_EN
            m_lane[m_cnt] <= m_sum[W] ? {W{1'b1}} : m_sum[W-1:0];
`else
            m_lane[m_cnt] <= m_sum[W-1:0];
`endif
            m_ovf[m_cnt] <= m_sum[W];
            if (m_cnt == LANES - 1) begin
                m_cnt  <= 0;
                m_hold <= 1'b1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    logic [DW-1:0]    exp_data;
    logic [LANES-1:0] exp_ovf;
    always_comb begin
        exp_data = '0;
        exp_ovf  = '0;
        for (int k = 0; k < LANES; k++) begin
            exp_data[(LANES-1-k)*W +: W] = m_lane[k];
            exp_ovf[LANES-1-k]           = m_ovf[k];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_in_ready", DW'(bus.in_ready), DW'(!m_hold));
            check("cyc_out_valid", DW'(bus.out_valid), DW'(m_hold));
            check("cyc_lane_idx", DW'(bus.lane_idx), DW'(m_cnt));
            check("cyc_out_data", bus.out_data, exp_data);
            check("cyc_out_ovf", DW'(bus.out_ovf), DW'(exp_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        logic hs;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 50) begin
            hs = bus.in_ready;
            tick();
            n++;
        end
        if (!hs) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_pair_timeout: got no handshake expected in_ready within 50 cycles");
        end
        bus.in_valid = 1'b0;
    endtask

    logic [DW-1:0] v030;
    logic [DW-1:0] v031;
    logic [DW-1:0] v032;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        v030 = 80'h0003_0007_000B_000F_0013;
`ifdef VEC_ADD_SAT_EN
        v031 = 80'hFFFF_0000_0000_0000_0000;
`else
        v031 = 80'h0001_0000_0000_0000_0000;
`endif
        v032 = 80'h001E_0046_006E_0096_00BE;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #2;
        check("rst_out_valid", DW'(bus.out_valid), '0);
        check("rst_lane_idx", DW'(bus.lane_idx), '0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_out_ovf", DW'(bus.out_ovf), '0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", DW'(bus.in_ready), DW'(1));

        // Back-to-back vector, consumer always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_pair(W'(2 * i + 1), W'(2 * i + 2));
        check("b2b_valid", DW'(bus.out_valid), DW'(1));
        check("b2b_data", bus.out_data, v030);
        check("b2b_ovf", DW'(bus.out_ovf), '0);
        tick();
        check("b2b_valid_one_cycle", DW'(bus.out_valid), '0);

        // Carry out of lane 0.
        send_pair(16'hFFFF, 16'h0002);
        for (int i = 0; i < 4; i++) send_pair('0, '0);
        check("ovf_data", bus.out_data, v031);
        check("ovf_flags", DW'(bus.out_ovf), DW'(5'b10000));
        tick();

        // Bubbles between pairs and back-pressure on the result.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_pair(W'(20 * i + 10), W'(20 * i + 20));
            if (i < 4) tick();
        end
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", DW'(bus.out_valid), DW'(1));
            check("hold_in_ready", DW'(bus.in_ready), '0);
            check("hold_data", bus.out_data, v032);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("hold_release_valid", DW'(bus.out_valid), '0);
        check("hold_release_ready", DW'(bus.in_ready), DW'(1));

        // Pair offered throughout HOLD waits for IDLE.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_pair(W'(i), W'(i));
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h1111;
        bus.in_b     = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            check("hv_in_ready", DW'(bus.in_ready), '0);
            check("hv_lane_idx", DW'(bus.lane_idx), '0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("hv_idle_ready", DW'(bus.in_ready), DW'(1));
        tick();
        bus.in_valid = 1'b0;
        check("hv_lane_idx_after", DW'(bus.lane_idx), DW'(1));
        check("hv_lane0", DW'(bus.out_data[DW-1 -: W]), DW'(16'h2222));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_pair('0, '0);
        check("hv_vec", bus.out_data, 80'h2222_0000_0000_0000_0000);
        tick();

        // Reset in the middle of a vector.
        for (int i = 0; i < 3; i++) send_pair(16'h0005, 16'h0005);
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mrst_valid", DW'(bus.out_valid), '0);
            check("mrst_data", bus.out_data, '0);
        end
        for (int i = 0; i < 5; i++) send_pair(W'(2 * i + 1), W'(2 * i + 2));
        check("mrst_vec", bus.out_data, v030);
        check("mrst_vec_valid", DW'(bus.out_valid), DW'(1));
        tick();

        // out_ready outside HOLD has no effect.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("idle_ordy_valid", DW'(bus.out_valid), '0);
            check("idle_ordy_idx", DW'(bus.lane_idx), '0);
            tick();
        end
        send_pair(16'h0001, 16'h0001);
        send_pair(16'h0002, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            check("fill_ordy_idx", DW'(bus.lane_idx), DW'(2));
            check("fill_ordy_valid", DW'(bus.out_valid), '0);
            tick();
        end
        for (int i = 0; i < 3; i++) send_pair(16'h0003, 16'h0003);
        check("fill_vec", bus.out_data, 80'h0002_0004_0006_0006_0006);
        tick();
        check("fill_vec_drain", DW'(bus.out_valid), '0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion by 200000");
        $fatal(1);
    end
endmodule
